// File: rtl/time_pkg.sv
// Shared types and default widths for time-unit consumers.
// Optional feature macro used by users of this package: TIME_GATE_LATE_CNT_EN.
package time_pkg;

    localparam int unsigned TIME_W = 48;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LATE_W = 16;

    typedef logic [TIME_W-1:0] time_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } gate_state_t;

endpackage

// File: rtl/unit_time_counter.sv
// Free-running time-unit counter: clear has priority over increment, wraps silently.
module unit_time_counter
    import time_pkg::*;
#(
    parameter int unsigned TW = TIME_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          tick,
    output logic [TW-1:0] count
);

    // Clear wins over a coincident tick; increment is modulo 2^TW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/time_unit_event_gate.sv
// Holds one timestamped event until curr_time reaches its release time, then
// offers it downstream over valid/ready.
// Optional macro TIME_GATE_LATE_CNT_EN: enables the saturating late-event counter;
// without it late_count is tied to zero.
module time_unit_event_gate
    import time_pkg::*;
#(
    parameter int unsigned TW = TIME_W,
    parameter int unsigned DW = DATA_W,
    parameter int unsigned LW = LATE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          unit_pulse,
    input  logic          time_reset,
    input  logic [TW-1:0] in_time,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] curr_time,
    output logic [LW-1:0] late_count
);

    gate_state_t   state;
    gate_state_t   state_nxt;
    logic [TW-1:0] held_time;
    logic [DW-1:0] held_data;
    logic          time_met;

    unit_time_counter #(
        .TW(TW)
    ) u_time (
        .clk   (clk),
        .reset (reset),
        .clear (time_reset),
        .tick  (unit_pulse),
        .count (curr_time)
    );

    // Unsigned compare against the registered (pre-increment) time; no wrap handling.
    assign time_met = (curr_time >= held_time);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept, wait for due time, hand off.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = WAIT;
            WAIT:    if (time_met)  state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake flags decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SEND:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the offered event on accept; untouched by time_reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_time <= '0;
            held_data <= '0;
        end else if ((state == IDLE) && in_valid) begin
            held_time <= in_time;
            held_data <= in_data;
        end
    end

    // Payload register loaded on entry to SEND so it holds the last release while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if ((state == WAIT) && time_met) begin
            out_data <= held_data;
        end
    end

`ifdef TIME_GATE_LATE_CNT_EN
    logic [LW-1:0] late_q;
    logic          late_accept;

    assign late_accept = (state == IDLE) && in_valid && (in_time < curr_time);

    // Saturating count of events accepted after their release time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            late_q <= '0;
        end else if (time_reset) begin
            late_q <= '0;
        end else if (late_accept && (late_q != {LW{1'b1}})) begin
            late_q <= late_q + LW'(1);
        end
    end

    assign late_count = late_q;
`else
    assign late_count = '0;
`endif

endmodule

// File: tb/tb_time_unit_event_gate.sv
// Self-checking bench for time_unit_event_gate: directed scenarios plus a
// randomized run checked against an event-level reference model.
module tb_time_unit_event_gate;

`ifdef TIME_GATE_LATE_CNT_EN
    localparam int LATE_EN = 1;
`else
    localparam int LATE_EN = 0;
`endif

    logic        clk;
    logic        reset;
    logic        unit_pulse, time_reset, in_valid, out_ready;
    logic [47:0] in_time;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [47:0] curr_time;
    logic [15:0] late_count;

    // Narrow instance for wrap and saturation checks.
    logic        p8, tr8, iv8, or8, ir8, ov8;
    logic [7:0]  it8, id8, od8, ct8;
    logic [3:0]  lc8;

    int n_cmp;
    int n_bad;

    // Reference model of the main instance, at transaction level.
    logic [47:0] m_time, m_t;
    logic [31:0] m_d, m_out;
    bit          m_busy, m_vis;
    int          m_late;

    time_unit_event_gate dut (
        .clk(clk), .reset(reset), .unit_pulse(unit_pulse), .time_reset(time_reset),
        .in_time(in_time), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .curr_time(curr_time), .late_count(late_count)
    );

    time_unit_event_gate #(.TW(8), .DW(8), .LW(4)) dut8 (
        .clk(clk), .reset(reset), .unit_pulse(p8), .time_reset(tr8),
        .in_time(it8), .in_data(id8), .in_valid(iv8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(or8),
        .curr_time(ct8), .late_count(lc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_time = '0; m_t = '0; m_d = '0; m_out = '0;
        m_busy = 0; m_vis = 0; m_late = 0;
    endfunction

    // Applies one clock edge's worth of behaviour using the current inputs.
    function automatic void model_edge();
        logic [47:0] t_pre;
        t_pre = m_time;
        if (time_reset) m_time = '0;
        else if (unit_pulse) m_time = m_time + 48'd1;
        if (time_reset) m_late = 0;
        if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_t = in_time; m_d = in_data;
                if (!time_reset && in_time < t_pre && m_late < 65535) m_late++;
            end
        end else if (!m_vis) begin
            if (t_pre >= m_t) begin m_vis = 1; m_out = m_d; end
        end else if (out_ready) begin
            m_busy = 0; m_vis = 0;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        unit_pulse = 0; time_reset = 0; in_valid = 0; out_ready = 0;
        in_time = '0; in_data = '0;
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (curr_time !== 48'd0) begin n_bad++; $display("FAIL reset_curr_time got %0d want 0", curr_time); end
        n_cmp++; if (late_count !== 16'd0) begin n_bad++; $display("FAIL reset_late got %0d want 0", late_count); end
        n_cmp++; if (ct8 !== 8'd0 || ir8 !== 1'b1) begin n_bad++; $display("FAIL reset_dut8 got t=%0d r=%b want 0/1", ct8, ir8); end
    endtask

    task automatic set_time(input int t);
        time_reset = 1; step(); time_reset = 0;
        unit_pulse = 1; repeat (t) step(); unit_pulse = 0;
    endtask

    task automatic test_scheduled();
        set_time(5);
        n_cmp++; if (curr_time !== 48'd5) begin n_bad++; $display("FAIL sched_time got %0d want 5", curr_time); end
        in_valid = 1; in_time = 48'd8; in_data = 32'hA5A5A5A5;
        step();
        in_valid = 0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL sched_accept in_ready got %b want 0", in_ready); end
        unit_pulse = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sched_early pulse %0d out_valid got %b want 0", i, out_valid); end
        end
        unit_pulse = 0;
        n_cmp++; if (curr_time !== 48'd8) begin n_bad++; $display("FAIL sched_time8 got %0d want 8", curr_time); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sched_release got v=%b d=%h want 1/a5a5a5a5", out_valid, out_data); end
        out_ready = 1; step(); out_ready = 0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL sched_handshake got v=%b r=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_late();
        set_time(20);
        in_valid = 1; in_time = 48'd3; in_data = 32'h0BAD_CAFE;
        step();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL late_accept out_valid got %b want 0", out_valid); end
        n_cmp++; if (late_count !== 16'(LATE_EN)) begin n_bad++; $display("FAIL late_count got %0d want %0d", late_count, LATE_EN); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_CAFE) begin n_bad++; $display("FAIL late_release got v=%b d=%h want 1/0badcafe", out_valid, out_data); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        set_time(0);
        in_valid = 1; in_time = 48'd0; in_data = d;
        step();
        in_data = ~d;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== d || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold cyc %0d got v=%b d=%h r=%b want 1/%h/0", i, out_valid, out_data, in_ready, d); end
        end
        in_valid = 0; out_ready = 1; step(); out_ready = 0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_handshake got v=%b r=%b want 0/1", out_valid, in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_data !== d) begin n_bad++; $display("FAIL bp_idle got r=%b d=%h want 1/%h", in_ready, out_data, d); end
    endtask

    task automatic test_time_reset_priority();
        set_time(100);
        in_valid = 1; in_time = 48'd50; in_data = 32'h5050_5050;
        time_reset = 1; unit_pulse = 1;
        step();
        in_valid = 0; time_reset = 0;
        n_cmp++; if (curr_time !== 48'd0) begin n_bad++; $display("FAIL trp_time got %0d want 0", curr_time); end
        n_cmp++; if (late_count !== 16'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL trp_accept got late=%0d r=%b want 0/0", late_count, in_ready); end
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL trp_early at t=%0d out_valid got %b want 0", curr_time, out_valid); end
        end
        unit_pulse = 0;
        n_cmp++; if (curr_time !== 48'd50) begin n_bad++; $display("FAIL trp_time50 got %0d want 50", curr_time); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h5050_5050) begin n_bad++; $display("FAIL trp_release got v=%b d=%h want 1/50505050", out_valid, out_data); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_async_reset();
        set_time(7);
        in_valid = 1; in_time = 48'd2; in_data = 32'h1234_5678;
        step(); in_valid = 0; step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre out_valid got %b want 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || curr_time !== 48'd0) begin n_bad++; $display("FAIL arst_now got v=%b r=%b t=%0d want 0/1/0", out_valid, in_ready, curr_time); end
        model_reset();
        #1 reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin n_bad++; $display("FAIL arst_after got v=%b d=%h want 0/0", out_valid, out_data); end
    endtask

    task automatic test_wrap_saturate();
        int hs;
        p8 = 1; repeat (255) step(); p8 = 0;
        n_cmp++; if (ct8 !== 8'd255) begin n_bad++; $display("FAIL wrap_pre got %0d want 255", ct8); end
        p8 = 1; step(); p8 = 0;
        n_cmp++; if (ct8 !== 8'd0) begin n_bad++; $display("FAIL wrap got %0d want 0", ct8); end
        p8 = 1; repeat (10) step(); p8 = 0;
        hs = 0;
        iv8 = 1; it8 = 8'd0; or8 = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ov8 && or8) hs++;
            if (i == 41) begin
                n_cmp++; if (lc8 !== 4'(14 * LATE_EN)) begin n_bad++; $display("FAIL late_inc got %0d want %0d", lc8, 14 * LATE_EN); end
            end
        end
        iv8 = 0; step();
        n_cmp++; if (hs != 20) begin n_bad++; $display("FAIL sat_events got %0d want 20", hs); end
        n_cmp++; if (lc8 !== 4'(15 * LATE_EN)) begin n_bad++; $display("FAIL late_sat got %0d want %0d", lc8, 15 * LATE_EN); end
        tr8 = 1; step(); tr8 = 0;
        n_cmp++; if (lc8 !== 4'd0 || ct8 !== 8'd0) begin n_bad++; $display("FAIL tr8_clear got l=%0d t=%0d want 0/0", lc8, ct8); end
        or8 = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            unit_pulse = ($urandom_range(0, 1) == 1);
            time_reset = ($urandom_range(0, 59) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_data    = $urandom;
            in_time    = m_time + 48'($urandom_range(0, 6));
            if (m_time >= 48'd4 && $urandom_range(0, 2) == 0) in_time = m_time - 48'($urandom_range(1, 4));
            step();
            n_cmp++;
            if (curr_time !== m_time || in_ready !== !m_busy || out_valid !== m_vis ||
                out_data !== m_out || late_count !== 16'(m_late * LATE_EN)) begin
                n_bad++;
                $display("FAIL rand cyc %0d got t=%0d r=%b v=%b d=%h l=%0d want t=%0d r=%b v=%b d=%h l=%0d",
                         i, curr_time, in_ready, out_valid, out_data, late_count,
                         m_time, !m_busy, m_vis, m_out, m_late * LATE_EN);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0;
        idle_inputs();
        p8 = 0; tr8 = 0; iv8 = 0; or8 = 0; it8 = '0; id8 = '0;
        model_reset();
        #12;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_scheduled();
        test_late();
        test_backpressure();
        test_time_reset_priority();
        test_async_reset();
        test_wrap_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_unit_event_gate.md
Name: time_unit_event_gate

Overview:
- Consumer of the time-unit pulse stream from the time-unit pulser.
- Keeps the FPGA's current time in units; each unit_pulse increments it by one.
- Holds one timestamped event from upstream until current time reaches the event's time, then releases it downstream over a valid/ready handshake.
- Sits between the host-event decoder and the spike/config output path; releases timed events on schedule.

Parameters:
- TW, 48, width of the time counter and event timestamps (units).
- DW, 32, width of the event payload.
- LW, 16, width of the late-event counter (optional feature only).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low (0 = in reset).
- unit_pulse  input  1  one-cycle tick from the time-unit pulser.
- time_reset  input  1  synchronous clear of curr_time.
- in_time  input  TW  release time of the offered event.
- in_data  input  DW  payload of the offered event.
- in_valid  input  1  upstream offers an event.
- in_ready  output  1  block accepts the event this cycle.
- out_data  output  DW  released payload.
- out_valid  output  1  released event available.
- out_ready  input  1  downstream accepts the event.
- curr_time  output  TW  current time in units.
- late_count  output  LW  saturating count of late events.

Behaviour:
- Reset (reset=0, async), all cleared:
  - curr_time=0, state=IDLE, in_ready=1, out_valid=0, out_data=0, late_count=0.
  - Held time/data registers cleared.
  - Reset mid-operation drops any held event.
- Time counter, evaluated each rising edge:
  - time_reset=1 -> curr_time=0 next cycle. Takes priority over a simultaneous unit_pulse.
  - Else unit_pulse=1 -> curr_time+1, modulo 2^TW; wraps from all-ones to 0 silently.
  - Held event is unaffected by time_reset.
- FSM states: IDLE, WAIT, SEND.
  - IDLE: in_ready=1. On in_valid=1, latch in_time/in_data and go to WAIT.
  - WAIT: in_ready=0, out_valid=0. Compare registered curr_time >= held_time (unsigned, no wrap handling). If true, go to SEND; else stay.
  - SEND: out_valid=1, out_data=held_data, stable until out_ready=1. On handshake, go to IDLE.
- in_ready is combinational from state only (state==IDLE); it never depends on in_valid.
- Latency: event accepted at edge k with time already met -> out_valid high from edge k+2.
- Event due on a tick:
  - unit_pulse at edge k makes curr_time equal held_time after edge k.
  - WAIT compare sees it at edge k+1; out_valid=1 after edge k+1.
  - Comparison always uses the pre-increment registered value.
- Events with in_time < curr_time at acceptance are late. They release with the same 2-cycle latency, never dropped.
- Throughput: at most one event per 3 cycles (IDLE->WAIT->SEND->IDLE). No bypass.
- out_data holds its last value in IDLE/WAIT. Only out_valid qualifies it.

Optional Feature:
- Macro TIME_GATE_LATE_CNT_EN.
- Defined:
  - late_count increments by 1 on each accepted event with in_time < curr_time at the accept edge.
  - Saturates at 2^LW-1.
  - Cleared by reset and by time_reset.
  - Simultaneous time_reset and late accept -> cleared (0).
- Undefined: late_count tied to 0; no counter logic synthesised. Port list is identical either way.

Decomposition:
- Shared package time_pkg:
  - typedefs time_t (logic [TW-1:0]) and gate_state_t (enum IDLE/WAIT/SEND).
  - Default width constants TIME_W=48, LATE_W=16.
- One natural sub-module: unit_time_counter, holding curr_time with clear/increment priority. Reusable by other time consumers.
- The gate FSM stays in the top module.

Test Plan:
- Reset low mid-SEND (out_valid=1) -> out_valid=0, in_ready=1, curr_time=0 immediately, without waiting for an edge.
- curr_time=5; offer in_time=8, data 0xA5A5A5A5 -> accepted; out_valid stays 0 through 3 unit_pulses; rises one cycle after curr_time reaches 8.
- curr_time=20; offer in_time=3 -> out_valid at accept+2 edges; with macro late_count=1, without it 0.
- SEND with out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0; out_ready=1 -> handshake, IDLE next cycle.
- time_reset and unit_pulse same cycle at curr_time=100 -> curr_time=0, held WAIT event (time 50) not released until curr_time re-reaches 50.
- TW=8, curr_time=255, unit_pulse -> curr_time=0; 2^LW late events with macro -> late_count saturates at 65535.
